// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin sharing of one simple dual-port RAM.
// Define RAM_ARB_PRIO_EN to give client 0 fixed top priority.
module ram_port_arbiter #(
  parameter int NREQ    = 4,
  parameter int D_WIDTH = 16,
  parameter int A_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ-1:0]           we,
  input  logic [NREQ*A_WIDTH-1:0]   addr,
  input  logic [NREQ*D_WIDTH-1:0]   wdata,
  output logic [NREQ-1:0]           gnt,
  output logic [NREQ-1:0]           rvalid,
  output logic [D_WIDTH-1:0]        rdata,
  output logic [A_WIDTH-1:0]        ram_address_write,
  output logic [D_WIDTH-1:0]        ram_data_write,
  output logic                      ram_write_enable,
  output logic [A_WIDTH-1:0]        ram_address_read,
  input  logic [D_WIDTH-1:0]        ram_data_read
);

  localparam int PW = (NREQ > 2) ? $clog2(NREQ) : 1;
  localparam logic [PW-1:0] LAST = PW'(NREQ - 1);
`ifdef RAM_ARB_PRIO_EN
  localparam logic [PW-1:0] PTR_RST = PW'(1);
`else
  localparam logic [PW-1:0] PTR_RST = '0;
`endif

  logic [PW-1:0]      rr_ptr;
  logic [PW-1:0]      rr_nxt;
  logic [PW-1:0]      gnt_idx;
  logic [PW-1:0]      cand;
  logic               gnt_any;
  logic               sel_we;
  logic [A_WIDTH-1:0] sel_addr;
  logic [D_WIDTH-1:0] sel_wdata;

  // First requester at or after rr_ptr, wrapping around.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = '0;
`ifdef RAM_ARB_PRIO_EN
    if (req[0]) begin
      gnt_any = 1'b1;
    end else begin
      for (int i = 0; i < NREQ - 1; i++) begin
        cand = PW'(1 + (int'(rr_ptr) - 1 + i) % (NREQ - 1));
        if (!gnt_any && req[cand]) begin
          gnt_any = 1'b1;
          gnt_idx = cand;
        end
      end
    end
`else
    for (int i = 0; i < NREQ; i++) begin
      cand = PW'((int'(rr_ptr) + i) % NREQ);
      if (!gnt_any && req[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
`endif
    if (rst) gnt_any = 1'b0;
  end

  always_comb begin
    gnt = '0;
    if (gnt_any) gnt[gnt_idx] = 1'b1;
  end

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_we    = we[i];
        sel_addr  = addr[i*A_WIDTH +: A_WIDTH];
        sel_wdata = wdata[i*D_WIDTH +: D_WIDTH];
      end
    end
  end

  assign ram_write_enable  = sel_we;
  assign ram_address_write = sel_we ? sel_addr : '0;
  assign ram_data_write    = sel_we ? sel_wdata : '0;
  assign ram_address_read  = (gnt_any && !sel_we) ? sel_addr : '0;
  assign rdata             = ram_data_read;

  // Pointer moves just past the winner; client 0 never moves it in prio mode.
  always_comb begin
    rr_nxt = rr_ptr;
`ifdef RAM_ARB_PRIO_EN
    if (gnt_any && gnt_idx != '0)
      rr_nxt = (gnt_idx == LAST) ? PW'(1) : gnt_idx + PW'(1);
`else
    if (gnt_any)
      rr_nxt = (gnt_idx == LAST) ? '0 : gnt_idx + PW'(1);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= PTR_RST;
      rvalid <= '0;
    end else begin
      rr_ptr <= rr_nxt;
      rvalid <= (gnt_any && !sel_we) ? gnt : '0;
    end
  end

`ifndef SYNTHESIS
  a_gnt_onehot: assert property (@(posedge clk) $onehot0(gnt));
  a_rv_onehot:  assert property (@(posedge clk) $onehot0(rvalid));
  a_ptr_range:  assert property (@(posedge clk) disable iff (rst)
                  int'(rr_ptr) < NREQ);
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed + random checks against a behavioural model.
// Honours RAM_ARB_PRIO_EN the same way as the design.
module tb_ram_port_arbiter;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int AW = 4;
  localparam int DEPTH = 2 ** AW;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req, we, gnt, rvalid;
  logic [N*AW-1:0]   addr;
  logic [N*DW-1:0]   wdata;
  logic [DW-1:0]     rdata, ram_data_write, ram_data_read;
  logic [AW-1:0]     ram_address_write, ram_address_read;
  logic              ram_write_enable;

  logic [DW-1:0]     ram [DEPTH];
  logic [DW-1:0]     pre [DEPTH];
  logic              do_pre;

  int                n_checks = 0;
  int                n_errors = 0;

  int                m_ptr;
  int                m_k;
  bit                m_pend;
  int                m_pc;
  logic [DW-1:0]     m_pd;
  logic [DW-1:0]     m_mem [DEPTH];

  always #5 clk = ~clk;

  ram_port_arbiter #(.NREQ(N), .D_WIDTH(DW), .A_WIDTH(AW)) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .we(we),
    .addr(addr),
    .wdata(wdata),
    .gnt(gnt),
    .rvalid(rvalid),
    .rdata(rdata),
    .ram_address_write(ram_address_write),
    .ram_data_write(ram_data_write),
    .ram_write_enable(ram_write_enable),
    .ram_address_read(ram_address_read),
    .ram_data_read(ram_data_read)
  );

  always @(posedge clk) begin
    if (do_pre) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= pre[i];
    end else if (ram_write_enable) begin
      ram[ram_address_write] <= ram_data_write;
    end
    ram_data_read <= ram[ram_address_read];
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ptr_rst();
`ifdef RAM_ARB_PRIO_EN
    return 1;
`else
    return 0;
`endif
  endfunction

  function automatic logic [AW-1:0] a_of(input int i);
    return addr[i*AW +: AW];
  endfunction

  function automatic logic [DW-1:0] d_of(input int i);
    return wdata[i*DW +: DW];
  endfunction

  // Winner = requester at smallest circular distance from the pointer.
  function automatic int pick();
    int best;
    int bd;
    int d;
    best = -1;
    bd = N + 1;
    if (rst) return -1;
`ifdef RAM_ARB_PRIO_EN
    if (req[0]) return 0;
    for (int i = 1; i < N; i++) begin
      if (req[i]) begin
        d = (i - m_ptr + N - 1) % (N - 1);
        if (d < bd) begin bd = d; best = i; end
      end
    end
`else
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        d = (i - m_ptr + N) % N;
        if (d < bd) begin bd = d; best = i; end
      end
    end
`endif
    return best;
  endfunction

  task automatic tick();
    logic [N-1:0] eg;
    logic ew;
    int kk;
    @(negedge clk);
    m_k = pick();
    kk = (m_k < 0) ? 0 : m_k;
    eg = (m_k < 0) ? '0 : (N'(1) << m_k);
    ew = (m_k >= 0) && we[kk];
    chk("gnt", gnt, eg);
    chk("ram_we", ram_write_enable, ew);
    chk("ram_waddr", ram_address_write, ew ? a_of(kk) : '0);
    chk("ram_wdata", ram_data_write, ew ? d_of(kk) : '0);
    chk("ram_raddr", ram_address_read,
        (m_k >= 0 && !ew) ? a_of(kk) : '0);
    chk("rvalid", rvalid, m_pend ? (32'd1 << m_pc) : 32'd0);
    if (m_pend) chk("rdata", rdata, m_pd);
    @(posedge clk);
    if (rst) begin
      m_ptr = ptr_rst();
      m_pend = 0;
      m_k = -1;
    end else begin
      m_pend = 0;
      if (m_k >= 0) begin
        if (we[m_k]) begin
          m_mem[a_of(m_k)] = d_of(m_k);
        end else begin
          m_pend = 1;
          m_pc = m_k;
          m_pd = m_mem[a_of(m_k)];
        end
`ifdef RAM_ARB_PRIO_EN
        if (m_k != 0) m_ptr = (m_k == N - 1) ? 1 : m_k + 1;
`else
        m_ptr = (m_k + 1) % N;
`endif
      end
    end
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    req = '1;
    we = '0;
    addr = '0;
    wdata = '0;
    do_pre = 1'b1;
    m_ptr = ptr_rst();
    m_pend = 0;
    m_k = -1;
    for (int i = 0; i < DEPTH; i++) begin
      pre[i] = (i < 8) ? DW'(16'h10 + i) : DW'($urandom);
      m_mem[i] = pre[i];
    end
    @(posedge clk);
    #1;
    do_pre = 1'b0;
    chk("rst_gnt", gnt, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_we", ram_write_enable, 0);
    tick();
    tick();

    rst = 1'b0;
    for (int i = 0; i < N; i++) addr[i*AW +: AW] = AW'(i);
    #2 chk("first_gnt", gnt, 4'b0001);
    tick();

    // single client streaming reads of the preloaded words
    req = 4'b0100;
    we = '0;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) addr[2*AW +: AW] = AW'(i);
      else req = '0;
      #2;
      if (i > 0) begin
        chk("stream_rvalid", rvalid, 4'b0100);
        chk("stream_rdata", rdata, 16'h10 + i - 1);
      end
      tick();
    end

    req = 4'b0010;
    we = 4'b0010;
    addr[1*AW +: AW] = 4'd5;
    wdata[1*DW +: DW] = 16'hBEEF;
    #2 chk("wr_gnt", gnt, 4'b0010);
    tick();
    we = '0;
    #2 chk("rd_gnt", gnt, 4'b0010);
    tick();
    req = '0;
    #2;
    chk("rd_rvalid", rvalid, 4'b0010);
    chk("rd_rdata", rdata, 16'hBEEF);
    tick();

    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b1111;
    we = '0;
    for (int i = 0; i < 9; i++) begin
      #2;
`ifndef RAM_ARB_PRIO_EN
      chk("fair_gnt", gnt, 32'd1 << (i % 4));
      if (i > 0) chk("fair_rvalid", rvalid, 32'd1 << ((i - 1) % 4));
`endif
      tick();
    end

    req = 4'b0100;
    tick();
    req = 4'b0101;
`ifndef RAM_ARB_PRIO_EN
    #2 chk("wrap_gnt0", gnt, 4'b0001);
    tick();
    #2 chk("wrap_gnt1", gnt, 4'b0100);
    tick();
    #2 chk("wrap_gnt2", gnt, 4'b0001);
    tick();
`else
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      #2 chk("prio_gnt0", gnt, 4'b0001);
      tick();
    end
    req = 4'b1110;
    for (int i = 0; i < 4; i++) begin
      #2 chk("prio_rr", gnt, 32'd1 << (1 + i % 3));
      tick();
    end
`endif

    req = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      rst = ($urandom_range(0, 60) == 0);
      for (int i = 0; i < N; i++) begin
        if (m_k == i) req[i] = 1'b0;
        if (!req[i] && $urandom_range(0, 2) == 0) begin
          req[i] = 1'b1;
          we[i] = 1'($urandom_range(0, 1));
          addr[i*AW +: AW] = AW'($urandom);
          wdata[i*DW +: DW] = DW'($urandom);
        end
      end
      tick();
    end
    rst = 1'b0;
    req = '0;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
